// File: rtl/ones_count_seq_pkg.sv
// Shared types and constants for the sequential ones counter.
package ones_count_seq_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Index width that stays at least one bit wide for a single-slice operand.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ones_count_seq_popcount3.sv
// Combinational ones count of three bits.
module popcount3 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [1:0] count
);

  always_comb begin
    count = {1'b0, a} + {1'b0, b} + {1'b0, c};
  end

endmodule

// File: rtl/ones_count_seq.sv
// Counts the ones in an operand three bits per cycle, LSB slice first.
//
// state | meaning
// IDLE  | waiting for start; result holds the last count
// COUNT | one 3-bit slice is added to the accumulator per cycle
// DONE  | one-cycle pulse; result has just been updated
module ones_count_seq
  import ones_count_seq_pkg::*;
#(
  parameter int WIDTH = 24,
  localparam int NSLICE = WIDTH / SLICE_W,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    result
);

  localparam int IW = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    result_q, result_d;

  logic [1:0]       slice_cnt;
  logic [CW-1:0]    acc_sum;

  popcount3 u_popcount3 (
    .a     (shift_q[0]),
    .b     (shift_q[1]),
    .c     (shift_q[2]),
    .count (slice_cnt)
  );

  assign acc_sum = acc_q + CW'(slice_cnt);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = data_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d   = acc_sum;
        shift_d = shift_q >> SLICE_W;
        // The index parks on the last slice rather than wrapping back to zero.
        if (idx_q == LAST_IDX) begin
          result_d = acc_sum;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == COUNT);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ones_count_seq.sv
// Randomized self-checking bench for ones_count_seq against a bit-loop ones model.
module tb_ones_count_seq;

  localparam int WIDTH  = 24;
  localparam int NSLICE = 8;
  localparam int CW     = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             busy;
  logic             done;
  logic [CW-1:0]    result;

  int vectors = 0;
  int miscompares = 0;
  logic [CW-1:0] last_result = '0;

  ones_count_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [CW-1:0] model_ones(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) n++;
    return CW'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation from IDLE and observes it; comparisons happen in callers.
  task automatic do_op(input logic [WIDTH-1:0] d, input logic [CW-1:0] prev,
                       output int busy_cnt, output int done_idx, output int done_cnt,
                       output logic [CW-1:0] res, output bit held_ok, output bit timed_out);
    busy_cnt = 0; done_idx = 0; done_cnt = 0; res = '0; held_ok = 1'b1; timed_out = 1'b1;
    start = 1'b1;
    data_in = d;
    step();
    start = 1'b0;
    data_in = WIDTH'($urandom);
    for (int k = 1; k <= 30; k++) begin
      if (busy) begin
        busy_cnt++;
        if (result !== prev) held_ok = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_idx = k;
        res = result;
      end
      if (done_idx != 0 && !done && !busy) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    data_in = 24'hFFFFFF;
    step();
    step();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++;
    if (result !== '0) begin miscompares++; $display("FAIL reset_result got %0d want 0", result); end
    rst_n = 1'b1;
    start = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
    last_result = '0;
  endtask

  task automatic test_zero();
    int bc, di, dc; logic [CW-1:0] r; bit h, t;
    do_op(24'h000000, last_result, bc, di, dc, r, h, t);
    vectors++;
    if (t !== 1'b0) begin miscompares++; $display("FAIL zero_timeout no done seen"); end
    vectors++;
    if (bc != NSLICE) begin miscompares++; $display("FAIL zero_busy_cycles got %0d want %0d", bc, NSLICE); end
    vectors++;
    if (di != NSLICE + 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d want %0d", di, NSLICE + 1); end
    vectors++;
    if (dc != 1) begin miscompares++; $display("FAIL zero_done_count got %0d want 1", dc); end
    vectors++;
    if (r !== 5'd0) begin miscompares++; $display("FAIL zero_result got %0d want 0", r); end
    last_result = 5'd0;
  endtask

  task automatic test_all_ones_hold();
    int bc, di, dc; logic [CW-1:0] r; bit h, t;
    do_op(24'hFFFFFF, last_result, bc, di, dc, r, h, t);
    vectors++;
    if (t !== 1'b0 || dc != 1) begin miscompares++; $display("FAIL ones_done got timeout=%0d dones=%0d want 0/1", t, dc); end
    vectors++;
    if (r !== 5'd24) begin miscompares++; $display("FAIL ones_result got %0d want 24", r); end
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if (result !== 5'd24 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL ones_hold cycle %0d got result=%0d busy=%b done=%b want 24/0/0", k, result, busy, done);
      end
      step();
    end
    last_result = 5'd24;
  endtask

  task automatic test_patterns();
    logic [WIDTH-1:0] pats [2];
    logic [CW-1:0]    want [2];
    int bc, di, dc; logic [CW-1:0] r; bit h, t;
    pats[0] = 24'h924924; want[0] = 5'd8;
    pats[1] = 24'hB6DB6D; want[1] = 5'd16;
    for (int i = 0; i < 2; i++) begin
      do_op(pats[i], last_result, bc, di, dc, r, h, t);
      vectors++;
      if (t !== 1'b0 || r !== want[i]) begin
        miscompares++;
        $display("FAIL pattern %h got result=%0d timeout=%0d want %0d", pats[i], r, t, want[i]);
      end
      vectors++;
      if (h !== 1'b1) begin miscompares++; $display("FAIL pattern_hold %h result changed during count", pats[i]); end
      last_result = want[i];
    end
  endtask

  task automatic test_random();
    int bc, di, dc; logic [CW-1:0] r, exp; bit h, t;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 20; i++) begin
      d = WIDTH'($urandom);
      exp = model_ones(d);
      do_op(d, last_result, bc, di, dc, r, h, t);
      vectors++;
      if (t !== 1'b0 || r !== exp || di != NSLICE + 1) begin
        miscompares++;
        $display("FAIL random %h got result=%0d done_cycle=%0d want %0d at %0d", d, r, di, exp, NSLICE + 1);
      end
      vectors++;
      if (h !== 1'b1) begin miscompares++; $display("FAIL random_hold %h result changed during count want %0d", d, last_result); end
      last_result = exp;
      if (($urandom & 1) != 0) step();
    end
  endtask

  task automatic test_ignore_start();
    int dones, busy_after;
    bit seen;
    dones = 0; busy_after = 0; seen = 1'b0;
    start = 1'b1;
    data_in = 24'h00000F;
    step();
    start = 1'b0;
    data_in = 24'h000000;
    step();
    step();
    start = 1'b1;
    data_in = 24'hFFFFFF;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin seen = 1'b1; break; end
      step();
    end
    if (seen) dones = 1;
    start = 1'b1;
    data_in = 24'hFFFFFF;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) dones++;
      if (busy) busy_after++;
      step();
    end
    vectors++;
    if (dones != 1) begin miscompares++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    vectors++;
    if (busy_after != 0) begin miscompares++; $display("FAIL ignore_busy_after got %0d cycles want 0", busy_after); end
    vectors++;
    if (result !== 5'd4) begin miscompares++; $display("FAIL ignore_result got %0d want 4", result); end
    last_result = 5'd4;
  endtask

  task automatic test_reset_abort();
    int dones, busys, bad_res;
    int bc, di, dc; logic [CW-1:0] r; bit h, t;
    dones = 0; busys = 0; bad_res = 0;
    start = 1'b1;
    data_in = 24'hFFFFFF;
    step();
    start = 1'b0;
    step();
    step();
    step();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (done) dones++;
      if (busy) busys++;
      if (result !== 5'd0) bad_res++;
      step();
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("FAIL abort_done got %0d pulses want 0", dones); end
    vectors++;
    if (busys != 0) begin miscompares++; $display("FAIL abort_busy got %0d cycles want 0", busys); end
    vectors++;
    if (bad_res != 0) begin miscompares++; $display("FAIL abort_result got %0d at end, nonzero %0d cycles, want 0", result, bad_res); end
    last_result = 5'd0;
    do_op(24'h000007, last_result, bc, di, dc, r, h, t);
    vectors++;
    if (t !== 1'b0 || r !== 5'd3) begin miscompares++; $display("FAIL abort_restart got %0d timeout=%0d want 3", r, t); end
    last_result = 5'd3;
  endtask

  task automatic test_back_to_back();
    int rises [$];
    int dones, bad_res;
    logic prev_busy;
    logic [WIDTH-1:0] op;
    logic [CW-1:0] exp;
    op = WIDTH'($urandom);
    exp = model_ones(op);
    dones = 0; bad_res = 0; prev_busy = 1'b0;
    start = 1'b1;
    data_in = op;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (busy && !prev_busy) rises.push_back(k);
      if (done) begin
        dones++;
        if (result !== exp) bad_res++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    for (int k = 0; k < 14; k++) step();
    vectors++;
    if (rises.size() != 4) begin miscompares++; $display("FAIL b2b_accepts got %0d want 4", rises.size()); end
    for (int i = 1; i < rises.size(); i++) begin
      vectors++;
      if (rises[i] - rises[i-1] != NSLICE + 2) begin
        miscompares++;
        $display("FAIL b2b_spacing %0d got %0d want %0d", i, rises[i] - rises[i-1], NSLICE + 2);
      end
    end
    vectors++;
    if (dones != 3) begin miscompares++; $display("FAIL b2b_done_count got %0d want 3", dones); end
    vectors++;
    if (bad_res != 0 || result !== exp) begin
      miscompares++;
      $display("FAIL b2b_result got %0d (bad %0d) want %0d", result, bad_res, exp);
    end
    last_result = exp;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_all_ones_hold();
    test_patterns();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
